// File: rtl/trdb_apb_cfg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : trdb_apb_cfg_bridge
//  Brief    : Registered APB slave to multi-target configuration bus bridge.
//             Decodes an address window per target, holds the request stable
//             until the selected target answers, returns a registered
//             response, and flags unmapped windows and target timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module trdb_apb_cfg_bridge #(
  parameter int APB_ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int NR_TARGETS        = 3,
  parameter int TARGET_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]        paddr,
  input  logic [DATA_WIDTH-1:0]            pwdata,
  input  logic                             pwrite,
  input  logic                             psel,
  input  logic                             penable,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic                             pready,
  output logic                             pslverr,
  input  logic [NR_TARGETS*DATA_WIDTH-1:0] per_rdata_i,
  input  logic [NR_TARGETS-1:0]            per_ready_i,
  output logic [DATA_WIDTH-1:0]            per_wdata_o,
  output logic [TARGET_ADDR_WIDTH-1:0]     per_addr_o,
  output logic                             per_we_o,
  output logic [NR_TARGETS-1:0]            per_valid_o
);

  localparam int c_idx_w = (NR_TARGETS > 1) ? $clog2(NR_TARGETS) : 1;
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int c_hi_lsb = TARGET_ADDR_WIDTH + c_idx_w;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [c_idx_w-1:0]             r_idx;
  logic                           r_miss;
  logic [TARGET_ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic                           r_we;
  logic [DATA_WIDTH-1:0]          r_prdata;
  logic                           r_err;
  logic [c_cnt_w-1:0]             r_cnt;

  logic                           w_access;
  logic [c_idx_w-1:0]             w_idx;
  logic                           w_mapped;
  logic                           w_sel_ready;
  logic [DATA_WIDTH-1:0]          w_sel_rdata;
  logic                           w_timeout;

  assign w_access = psel & penable;
  assign w_idx    = paddr[TARGET_ADDR_WIDTH +: c_idx_w];
  assign w_mapped = ({1'b0, w_idx} < (c_idx_w + 1)'(NR_TARGETS));

  // Address bits above the target index do not take part in decoding.
  generate
    if (APB_ADDR_WIDTH > c_hi_lsb) begin : g_unused_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^paddr[APB_ADDR_WIDTH-1:c_hi_lsb];
    end
  endgenerate

  // Timeout fires in the TIMEOUT_CYCLES-th REQ cycle; counter holds cycles already spent.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
      assign w_timeout = (r_cnt == c_cnt_last);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // Pick the ready and read data of the currently addressed target only.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < NR_TARGETS; k++) begin
      if (r_idx == c_idx_w'(k)) begin
        w_sel_ready = per_ready_i[k];
        w_sel_rdata = per_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot request valid, decoded from the held index while in REQ.
  generate
    for (genvar k = 0; k < NR_TARGETS; k++) begin : g_valid
      assign per_valid_o[k] = (r_state == ST_REQ) && (r_idx == c_idx_w'(k));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and response strobes. An unmapped access still passes through
  // one REQ cycle (with no valid raised) so it shares the minimum latency.
  always_comb begin
    w_state_nxt = r_state;
    pready      = 1'b0;
    pslverr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (r_miss || w_sel_ready || w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        pready      = 1'b1;
        pslverr     = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx    <= '0;
      r_miss   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_prdata <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_access) begin
          r_addr  <= paddr[TARGET_ADDR_WIDTH-1:0];
          r_wdata <= pwdata;
          r_we    <= pwrite;
          r_idx   <= w_idx;
          r_miss  <= ~w_mapped;
          r_cnt   <= '0;
          if (!w_mapped) begin
            r_err    <= 1'b1;
            r_prdata <= '0;
          end
        end
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
        if (!r_miss) begin
          if (w_sel_ready) begin
            r_prdata <= r_we ? '0 : w_sel_rdata;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_prdata <= '0;
            r_err    <= 1'b1;
          end
        end
      end
    end
  end

  assign prdata      = r_prdata;
  assign per_addr_o  = r_addr;
  assign per_wdata_o = r_wdata;
  assign per_we_o    = r_we;

endmodule
`default_nettype wire

// File: tb/tb_trdb_apb_cfg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trdb_apb_cfg_bridge
//  Brief    : Self-checking bench for trdb_apb_cfg_bridge: directed transfers
//             plus randomized ones, scored against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trdb_apb_cfg_bridge;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NT  = 3;
  localparam int TAW = 8;
  localparam int TO  = 16;
  localparam int IW  = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [AW-1:0]      paddr = '0;
  logic [DW-1:0]      pwdata = '0;
  logic               pwrite = 1'b0;
  logic               psel = 1'b0;
  logic               penable = 1'b0;
  logic [DW-1:0]      prdata;
  logic               pready;
  logic               pslverr;
  logic [NT*DW-1:0]   per_rdata_i = '0;
  logic [NT-1:0]      per_ready_i = '0;
  logic [DW-1:0]      per_wdata_o;
  logic [TAW-1:0]     per_addr_o;
  logic               per_we_o;
  logic [NT-1:0]      per_valid_o;

  int vectors = 0;
  int miscompares = 0;

  trdb_apb_cfg_bridge #(
    .APB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_TARGETS(NT),
    .TARGET_ADDR_WIDTH(TAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .per_rdata_i(per_rdata_i), .per_ready_i(per_ready_i),
    .per_wdata_o(per_wdata_o), .per_addr_o(per_addr_o), .per_we_o(per_we_o),
    .per_valid_o(per_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"}, 64'(prdata), 64'd0);
    chk({tag, "_pready"}, 64'(pready), 64'd0);
    chk({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    chk({tag, "_valid"}, 64'(per_valid_o), 64'd0);
    chk({tag, "_addr"}, 64'(per_addr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(per_wdata_o), 64'd0);
    chk({tag, "_we"}, 64'(per_we_o), 64'd0);
  endtask

  // One APB transfer. dly = wait cycles before the addressed target readies
  // (negative: never). spur = ready bits raised on the other targets.
  task automatic xfer(input string tag, input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] rd,
                      input logic [NT-1:0] spur);
    int idx, exp_v, exp_pr, nv, s;
    bit mapped, exp_err, stable_ok, done;
    logic [DW-1:0] exp_rd;
    logic [NT-1:0] onehot;

    // Transaction-level expectation straight from the window/timeout rules.
    idx    = int'(addr >> TAW) % (1 << IW);
    mapped = (idx < NT);
    if (!mapped) begin
      exp_v = 0; exp_err = 1'b1;
    end else if (dly >= 0 && dly < TO) begin
      exp_v = dly + 1; exp_err = 1'b0;
    end else begin
      exp_v = TO; exp_err = 1'b1;
    end
    exp_rd = (exp_err || wr) ? '0 : rd;
    exp_pr = ((exp_v == 0) ? 1 : exp_v) + 1;
    onehot = mapped ? NT'(1 << idx) : '0;

    for (int k = 0; k < NT; k++) per_rdata_i[k*DW +: DW] = $urandom;
    if (mapped) per_rdata_i[idx*DW +: DW] = rd;
    per_ready_i = spur & ~onehot;

    paddr = addr; pwdata = wd; pwrite = wr;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();

    nv = 0; stable_ok = 1'b1; done = 1'b0; s = 1;
    while (s <= 60 && !done) begin
      if (pready) begin
        done = 1'b1;
        if (per_valid_o !== '0) stable_ok = 1'b0;
      end else begin
        if (per_valid_o !== '0) begin
          nv++;
          if (per_valid_o !== onehot || per_addr_o !== addr[TAW-1:0] ||
              per_we_o !== wr || per_wdata_o !== wd) stable_ok = 1'b0;
        end
        if (mapped && dly >= 0 && nv == dly + 1) per_ready_i[idx] = 1'b1;
        tick();
        s++;
      end
    end
    chk({tag, "_done_in_bound"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(s), 64'(exp_pr));
    chk({tag, "_valid_cycles"}, 64'(nv), 64'(exp_v));
    chk({tag, "_req_stable"}, 64'(stable_ok), 64'd1);
    chk({tag, "_pslverr"}, 64'(pslverr), 64'(exp_err));
    chk({tag, "_prdata"}, 64'(prdata), 64'(exp_rd));

    psel = 1'b0; penable = 1'b0; per_ready_i = '0;
    tick();
    chk({tag, "_pready_drop"}, 64'(pready), 64'd0);
    chk({tag, "_pslverr_drop"}, 64'(pslverr), 64'd0);
    chk({tag, "_prdata_hold"}, 64'(prdata), 64'(exp_rd));
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rdly;
    int sel;

    #2;
    chk_all_zero("reset");
    #10 rst_ni = 1'b1;
    tick();

    xfer("t1_wr_tgt1", 12'h104, 1'b1, 32'hDEADBEEF, 0, 32'h0, 3'b000);
    xfer("t2_rd_tgt2_wait5", 12'h2F0, 1'b0, 32'h0, 5, 32'h12345678, 3'b000);
    xfer("t3_unmapped", 12'h300, 1'b0, 32'h0, 0, 32'h0, 3'b000);
    xfer("t3_unmapped_hibits", 12'hF3C, 1'b1, 32'h5555AAAA, 0, 32'h0, 3'b000);
    xfer("t4_timeout", 12'h010, 1'b1, 32'hCAFEF00D, -1, 32'h0, 3'b000);
    xfer("t4_after_timeout", 12'h120, 1'b0, 32'h0, 0, 32'hA5A5A5A5, 3'b000);
    xfer("t5_ready_last", 12'h044, 1'b0, 32'h0, 15, 32'h0BADCAFE, 3'b000);
    xfer("t5_spurious", 12'h0FF, 1'b0, 32'h0, 2, 32'h13572468, 3'b110);
    xfer("t5_spur_never", 12'h0FF, 1'b0, 32'h0, -1, 32'h11112222, 3'b110);

    // Async reset during the third REQ cycle.
    per_ready_i = '0;
    paddr = 12'h0A0; pwdata = 32'h77778888; pwrite = 1'b1;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_valid_before_rst", 64'(per_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk_all_zero("t6_in_rst");
    psel = 1'b0; penable = 1'b0;
    tick();
    #3 rst_ni = 1'b1;
    tick();
    chk_all_zero("t6_after_rst");
    xfer("t6_rd_after_rst", 12'h010, 1'b0, 32'h0, 0, 32'h89ABCDEF, 3'b000);

    // Randomized transfers against the model.
    for (int n = 0; n < 24; n++) begin
      ra  = AW'($urandom_range(0, (1 << AW) - 1));
      sel = $urandom_range(0, 5);
      case (sel)
        0: rdly = 0;
        1: rdly = 1;
        2: rdly = -1;
        3: rdly = TO - 1;
        default: rdly = $urandom_range(0, 20);
      endcase
      xfer("rand", ra, 1'($urandom_range(0, 1)), $urandom, rdly, $urandom,
           NT'($urandom_range(0, (1 << NT) - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
